// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Show-ahead instruction FIFO between fetch and decode with    |
// |               single-cycle flush on PC redirect.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_inst,
  input  logic [WIDTH-1:0]         push_pc,
  input  logic [WIDTH-1:0]         push_normal,
  input  logic                     push_bp_en,
  input  logic                     push_bp_decision,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_inst,
  output logic [WIDTH-1:0]         pop_pc,
  output logic [WIDTH-1:0]         pop_normal,
  output logic                     pop_bp_en,
  output logic                     pop_bp_decision,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_inst   [DEPTH];
  logic [WIDTH-1:0]   r_pc     [DEPTH];
  logic [WIDTH-1:0]   r_normal [DEPTH];
  logic               r_bp_en  [DEPTH];
  logic               r_bp_dec [DEPTH];

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_pop_valid;
  logic               w_push_ready;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_push_ready = (r_count != c_full);
  assign w_pop_valid  = (r_count != '0);
  assign w_push       = push_valid && w_push_ready && !flush;
  assign w_pop        = w_pop_valid && pop_ready && !flush;

  assign push_ready   = w_push_ready;
  assign pop_valid    = w_pop_valid;
  assign count        = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wr_ptr]   <= push_inst;
      r_pc[r_wr_ptr]     <= push_pc;
      r_normal[r_wr_ptr] <= push_normal;
      r_bp_en[r_wr_ptr]  <= push_bp_en;
      r_bp_dec[r_wr_ptr] <= push_bp_decision;
    end
  end

  always_comb begin
    pop_inst        = NOP_INST;
    pop_pc          = '0;
    pop_normal      = '0;
    pop_bp_en       = 1'b0;
    pop_bp_decision = 1'b0;
    if (w_pop_valid) begin
      pop_inst        = r_inst[r_rd_ptr];
      pop_pc          = r_pc[r_rd_ptr];
      pop_normal      = r_normal[r_rd_ptr];
      pop_bp_en       = r_bp_en[r_rd_ptr];
      pop_bp_decision = r_bp_dec[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Self-checking bench for fetch_queue with a queue scoreboard. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] normal;
    logic        bp_en;
    logic        bp_dec;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic [31:0] push_normal;
  logic        push_bp_en;
  logic        push_bp_decision;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_inst;
  logic [31:0] pop_pc;
  logic [31:0] pop_normal;
  logic        pop_bp_en;
  logic        pop_bp_decision;
  logic        flush;
  logic [2:0]  count;

  entry_t sb[$];
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_inst        (push_inst),
    .push_pc          (push_pc),
    .push_normal      (push_normal),
    .push_bp_en       (push_bp_en),
    .push_bp_decision (push_bp_decision),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_ready),
    .pop_inst         (pop_inst),
    .pop_pc           (pop_pc),
    .pop_normal       (pop_normal),
    .pop_bp_en        (pop_bp_en),
    .pop_bp_decision  (pop_bp_decision),
    .flush            (flush),
    .count            (count)
  );

  task automatic set_push(input logic [31:0] pc, input logic [31:0] inst,
                          input logic en, input logic dec);
    push_valid       = 1'b1;
    push_pc          = pc;
    push_inst        = inst;
    push_normal      = pc + 32'd4;
    push_bp_en       = en;
    push_bp_decision = dec;
  endtask

  // Scoreboard consumer: compare the DUT against the model, then advance one edge.
  task automatic cycle();
    entry_t     head;
    entry_t     got;
    logic [1:0] diff;
    bit         full;
    bit         empty;
    full  = (sb.size() == DEPTH);
    empty = (sb.size() == 0);
    checks++;
    if (count !== 3'(sb.size())) begin
      errors++; $display("FAIL sb_count: got %0d expected %0d", count, sb.size());
    end
    checks++;
    if (pop_valid !== !empty) begin
      errors++; $display("FAIL sb_pop_valid: got %b expected %b", pop_valid, !empty);
    end
    checks++;
    if (push_ready !== !full) begin
      errors++; $display("FAIL sb_push_ready: got %b expected %b", push_ready, !full);
    end
    checks++;
    if (count > 3'(DEPTH)) begin
      errors++; $display("FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
    end
    diff = dut.r_wr_ptr - dut.r_rd_ptr;
    checks++;
    if ((count == 3'(DEPTH)) ? (diff !== 2'd0) : ({1'b0, diff} !== count)) begin
      errors++; $display("FAIL ptr_count: got diff %0d count %0d expected consistent", diff, count);
    end
    head = empty ? {NOP, 32'h0, 32'h0, 1'b0, 1'b0} : sb[0];
    got  = {pop_inst, pop_pc, pop_normal, pop_bp_en, pop_bp_decision};
    checks++;
    if (got !== head) begin
      errors++; $display("FAIL sb_head: got inst=%h pc=%h nrm=%h bp=%b%b expected inst=%h pc=%h nrm=%h bp=%b%b",
        got.inst, got.pc, got.normal, got.bp_en, got.bp_dec,
        head.inst, head.pc, head.normal, head.bp_en, head.bp_dec);
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (!empty && pop_ready) void'(sb.pop_front());
      if (push_valid && !full)
        sb.push_back({push_inst, push_pc, push_normal, push_bp_en, push_bp_decision});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    push_inst = '0; push_pc = '0; push_normal = '0;
    push_bp_en = 1'b0; push_bp_decision = 1'b0;
    #2;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: got cnt=%0d pv=%b pr=%b expected 0 0 1", count, pop_valid, push_ready);
    end
    checks++;
    if (pop_inst !== NOP || pop_pc !== 32'h0) begin
      errors++; $display("FAIL reset_head: got inst=%h pc=%h expected %h 0", pop_inst, pop_pc, NOP);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) cycle();
    checks++;
    if (pop_inst !== NOP) begin
      errors++; $display("FAIL idle_nop: got %h expected %h", pop_inst, NOP);
    end
  endtask

  task automatic test_fill_drain();
    pop_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_push(32'(k * 4), 32'(32'hA0 + k), 1'b0, 1'b0);
      cycle();
    end
    checks++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got cnt=%0d pr=%b expected 4 0", count, push_ready);
    end
    set_push(32'h10, 32'hA4, 1'b0, 1'b0);
    cycle();
    checks++;
    if (count !== 3'd4 || pop_pc !== 32'h0) begin
      errors++; $display("FAIL held_push: got cnt=%0d pc=%h expected 4 0", count, pop_pc);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pop_pc !== 32'(k * 4) || pop_inst !== 32'(32'hA0 + k)) begin
        errors++; $display("FAIL drain_order: got pc=%h inst=%h expected pc=%h", pop_pc, pop_inst, k * 4);
      end
      cycle();
    end
    pop_ready = 1'b0;
    cycle();
  endtask

  task automatic test_stream_wrap();
    pop_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_push(32'(32'h100 + 4 * k), 32'(32'hB00 + k), 1'b0, 1'b0);
      cycle();
      checks++;
      if (count !== 3'd1 || pop_pc !== 32'(32'h100 + 4 * k)) begin
        errors++; $display("FAIL stream: got cnt=%0d pc=%h expected 1 %h", count, pop_pc, 32'h100 + 4 * k);
      end
    end
    push_valid = 1'b0;
    repeat (2) cycle();
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    pop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_push(32'(32'h180 + 4 * k), 32'(32'hC0 + k), 1'b0, 1'b0);
      cycle();
    end
    flush = 1'b1;
    set_push(32'h1F0, 32'hCF, 1'b0, 1'b0);
    pop_ready = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1 || pop_inst !== NOP) begin
      errors++; $display("FAIL flush_state: got cnt=%0d pv=%b pr=%b inst=%h expected 0 0 1 %h",
        count, pop_valid, push_ready, pop_inst, NOP);
    end
    set_push(32'h200, 32'hD0, 1'b0, 1'b0);
    pop_ready = 1'b0;
    cycle();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    checks++;
    if (pop_pc !== 32'h200) begin
      errors++; $display("FAIL flush_next: got pc=%h expected 200", pop_pc);
    end
    cycle();
    pop_ready = 1'b0;
  endtask

  task automatic test_bp_tags();
    pop_ready = 1'b0;
    set_push(32'h40, 32'hE0, 1'b1, 1'b1);
    cycle();
    set_push(32'h44, 32'hE1, 1'b1, 1'b0);
    cycle();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    checks++;
    if ({pop_bp_en, pop_bp_decision} !== 2'b11 || pop_normal !== 32'h44) begin
      errors++; $display("FAIL bp_first: got bp=%b%b nrm=%h expected 11 44", pop_bp_en, pop_bp_decision, pop_normal);
    end
    cycle();
    checks++;
    if ({pop_bp_en, pop_bp_decision} !== 2'b10 || pop_normal !== 32'h48) begin
      errors++; $display("FAIL bp_second: got bp=%b%b nrm=%h expected 10 48", pop_bp_en, pop_bp_decision, pop_normal);
    end
    cycle();
    pop_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    pop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_push(32'(32'h280 + 4 * k), 32'(32'hF0 + k), 1'b0, 1'b0);
      cycle();
    end
    push_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1 || pop_inst !== NOP) begin
      errors++; $display("FAIL async_reset: got cnt=%0d pv=%b pr=%b inst=%h expected 0 0 1 %h",
        count, pop_valid, push_ready, pop_inst, NOP);
    end
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    set_push(32'h300, 32'h77, 1'b0, 1'b0);
    cycle();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    checks++;
    if (pop_pc !== 32'h300 || count !== 3'd1) begin
      errors++; $display("FAIL resume: got pc=%h cnt=%0d expected 300 1", pop_pc, count);
    end
    repeat (2) cycle();
    pop_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream_wrap();
    test_flush();
    test_bp_tags();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Show-ahead instruction FIFO between the fetch stage (PC register, instruction memory, branch-prediction decode) and the decode pipeline register.
- Buffers each fetched instruction with its PC, PC+4 and branch-predictor tags.
- Lets fetch keep running while decode is stalled.
- Discards all buffered wrong-path instructions in one cycle when a branch misprediction or jump redirects the PC.

Parameters:
- WIDTH, 32, instruction and PC width in bits.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- NOP_INST, 32'h0000_0013, instruction presented on pop_inst while the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- push_valid  input  1  fetch presents a valid entry this cycle.
- push_ready  output  1  queue can accept an entry this cycle.
- push_inst  input  WIDTH  fetched instruction.
- push_pc  input  WIDTH  PC of the fetched instruction.
- push_normal  input  WIDTH  PC+4 of the fetched instruction.
- push_bp_en  input  1  fetch decoder flagged the instruction as a conditional branch.
- push_bp_decision  input  1  gshare taken prediction.
- pop_valid  output  1  head entry is valid.
- pop_ready  input  1  decode accepts the head entry (this is the inverse of the decode stall).
- pop_inst  output  WIDTH  head instruction.
- pop_pc  output  WIDTH  head PC.
- pop_normal  output  WIDTH  head PC+4.
- pop_bp_en  output  1  head branch flag.
- pop_bp_decision  output  1  head prediction.
- flush  input  1  redirect: discard all entries.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0:
  - write pointer, read pointer and count are 0;
  - pop_valid=0 and push_ready=1;
  - pop_inst=NOP_INST, and pop_pc, pop_normal, pop_bp_en and pop_bp_decision are 0.
- Storage: DEPTH entries, each holding {inst, pc, normal, bp_en, bp_decision}. The storage array is not required to be reset.
- Push: occurs when push_valid && push_ready && !flush. The entry is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH (natural wrap).
- Pop: occurs when pop_valid && pop_ready && !flush. rd_ptr advances by 1 modulo DEPTH.
- Count update: count += push - pop. A simultaneous push and pop leaves count unchanged.
- push_ready = (count != DEPTH). It is registered-state only, with no combinational dependency on pop_ready. When full, a same-cycle pop does not admit a push.
- pop_valid = (count != 0).
- Head outputs are driven combinationally from entry[rd_ptr] while pop_valid=1. When empty they take the reset values (NOP_INST and zeros).
- Latency: there is no bypass. An entry pushed at edge N is first visible on pop_* in the cycle after edge N. Minimum fetch-to-decode latency is therefore 1 cycle, and an empty queue never forwards push_* directly.
- Flush: has priority over push and pop. At the edge where flush=1:
  - count, wr_ptr and rd_ptr are set to 0;
  - the same-cycle push is dropped and no pop is counted;
  - in the next cycle pop_valid=0 and push_ready=1.
  - Flush while the queue is already empty has no effect beyond the pointer reset.
- Push while full (push_valid=1, push_ready=0): ignored. The producer must hold the entry; the queue state is unchanged.
- Pop while empty (pop_ready=1, pop_valid=0): ignored and count stays 0. Decode sees NOP_INST, which is a harmless bubble.
- Reset asserted mid-operation: all state clears immediately, without waiting for clk. Entries are not preserved.
- Ordering: strict FIFO, so the pop order equals the push order across pointer wrap.
- Assertions for the bench:
  - count <= DEPTH at all times;
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when full, where the pointers are equal and count == DEPTH.

Test Plan:
- Reset then idle: rst=0 then released, no push → count=0, pop_valid=0, push_ready=1, pop_inst=32'h0000_0013.
- Fill then drain: with pop_ready=0, push pc=0x00,0x04,0x08,0x0C (inst 0xA0..0xA3).
  - count goes 1→4 and push_ready=0 after the 4th push.
  - A 5th push (pc=0x10) is held with no state change.
  - Then pop_ready=1 → 4 pops in order 0x00,0x04,0x08,0x0C. push_ready=1 from the cycle after the first pop.
- Streaming with wrap: push and pop every cycle for 10 entries pc=0x100+4k, starting empty.
  - Each entry is visible exactly 1 cycle after its push and count stays at 1.
  - The pointers wrap twice and the pop sequence matches the push sequence.
- Flush with concurrent traffic: queue holds 3 entries; assert flush together with push_valid=1 and pop_ready=1.
  - Next cycle: count=0, pop_valid=0, push_ready=1, pop_inst=NOP.
  - The entry pushed after the flush (pc=0x200) is the next one popped.
- Predictor tags: push pc=0x40 with bp_en=1, bp_decision=1, then pc=0x44 with bp_en=1, bp_decision=0 → the pops show {1,1} then {1,0}, and pop_normal shows 0x44 then 0x48.
- Asynchronous reset mid-stream: assert rst=0 between clock edges with count=3 → count=0 and pop_valid=0 immediately, before the next edge; normal operation resumes after release.
